uart_rx: RTL and testbench

- Receiver counterpart to the board's UART transmitter: recovers 8N1 bytes from a serial line and presents them on a valid/ready byte interface.
- Used for loopback of TXD back into the FPGA and for host-to-board commands (e.g. mode select replacing btn2).
- Contains an input synchroniser, a mid-bit sampling FSM, a one-entry output holding register, and framing-error and overrun flags.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
// The transmitter imports the same baud default so both ends stay consistent.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 104;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is a parameter so an idle-high line reads idle out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Capture the asynchronous input and hand it to the second stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry output register.
// Flags framing errors (stop bit low) and overruns (byte lost to a full register).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (rst_n),
    .d     (RXD),
    .q     (rxd_s)
  );

  // Receive FSM plus holding register; every output is registered here.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A completing byte below overrides this drop in the same cycle.
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (!rxd_s) begin
            state_r <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt_r == CNT_HALF) begin
            cnt_r <= '0;
            if (!rxd_s) begin
              state_r   <= DATA;
              bit_idx_r <= 3'd0;
            end else begin
              state_r <= IDLE;
              busy    <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r     <= '0;
            shift_r   <= {rxd_s, shift_r[DATA_BITS-1:1]};
            bit_idx_r <= bit_idx_r + 3'd1;
            if (bit_idx_r == IDX_LAST) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
            if (rxd_s) begin
              state_r <= IDLE;
              busy    <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_r;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state_r   <= BREAK;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        BREAK: begin
          // Hold here until the line idles so a long break flags only once.
          cnt_r <= '0;
          if (rxd_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit with a byte scoreboard.
// Expected bytes are queued when a frame is sent and popped on each handshake.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         tests = 0;
  int         fails = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK       (clk),
    .rst_n     (rst_n),
    .RXD       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: count flag pulses and score every accepted byte.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'(rx_data), 32'hFFFF_FFFF);
      end else begin
        check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one 8N1 frame starting just after a rising edge; optionally pulses
  // rx_ready high for the single cycle ending at rising edge number ready_edge.
  task automatic send(input logic [7:0] b, input logic stop, input int ready_edge);
    logic [9:0] fr;
    fr  = {stop, b, 1'b0};
    rxd = 1'b0;
    for (int k = 1; k <= 10 * CPB; k++) begin
      @(posedge clk);
      #1;
      if (k < 10 * CPB) rxd = fr[k / CPB];
      else              rxd = 1'b1;
      if (k == ready_edge - 1) rx_ready = 1'b1;
      if (k == ready_edge)     rx_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    #3;
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(4);

    // Plain byte decode with the consumer always ready.
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, -1);
    wait_cycles(4);
    check("a5_consumed", 32'(exp_q.size()), 32'd0);
    check("a5_valid_dropped", 32'(rx_valid), 32'd0);
    check("a5_busy_idle", 32'(busy), 32'd0);
    check("a5_no_frame_err", 32'(fe_cnt), 32'd0);
    check("a5_no_overrun", 32'(ov_cnt), 32'd0);

    // Two-cycle start glitch is rejected at the mid-point check.
    rxd = 1'b0;
    wait_cycles(2);
    rxd = 1'b1;
    wait_cycles(2);
    check("glitch_busy_seen", 32'(busy), 32'd1);
    wait_cycles(3);
    check("glitch_back_idle", 32'(busy), 32'd0);
    check("glitch_no_frame_err", 32'(fe_cnt), 32'd0);
    check("glitch_no_valid", 32'(rx_valid), 32'd0);

    // Low stop bit, then a good frame.
    send(8'h3C, 1'b0, -1);
    wait_cycles(4);
    check("ferr_once", 32'(fe_cnt), 32'd1);
    check("ferr_no_valid", 32'(rx_valid), 32'd0);
    check("ferr_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, -1);
    wait_cycles(4);
    check("after_ferr_consumed", 32'(exp_q.size()), 32'd0);
    check("after_ferr_no_new_err", 32'(fe_cnt), 32'd1);

    // Held-low break flags exactly once.
    rxd = 1'b0;
    wait_cycles(30 * CPB);
    check("break_one_err", 32'(fe_cnt), 32'd2);
    check("break_busy", 32'(busy), 32'd1);
    rxd = 1'b1;
    wait_cycles(4);
    check("break_released", 32'(busy), 32'd0);
    check("break_still_one", 32'(fe_cnt), 32'd2);

    // Overrun: second back-to-back byte hits a full register.
    rx_ready = 1'b0;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, -1);
    send(8'h34, 1'b1, -1);
    wait_cycles(2);
    check("ovr_pulse_once", 32'(ov_cnt), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h12);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    rx_ready = 1'b1;
    wait_cycles(1);
    check("ovr_valid_drop", 32'(rx_valid), 32'd0);
    check("ovr_data_stays", 32'(rx_data), 32'h12);
    check("ovr_consumed", 32'(exp_q.size()), 32'd0);

    // Read of 0x12 in the very cycle 0x56 completes.
    rx_ready = 1'b0;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, -1);
    exp_q.push_back(8'h56);
    send(8'h56, 1'b1, 79);
    wait_cycles(2);
    check("simul_valid", 32'(rx_valid), 32'd1);
    check("simul_data", 32'(rx_data), 32'h56);
    check("simul_no_overrun", 32'(ov_cnt), 32'd1);
    check("simul_old_read", 32'(exp_q.size()), 32'd1);
    rx_ready = 1'b1;
    wait_cycles(2);
    check("simul_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of the data bits.
    rxd = 1'b0;
    wait_cycles(44);
    check("rst_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", 32'(rx_data), 32'h00);
    check("rst_mid_valid", 32'(rx_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ferr", 32'(frame_err), 32'd0);
    rxd = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(20);
    check("rst_no_ferr_after", 32'(fe_cnt), 32'd2);
    check("rst_no_ovr_after", 32'(ov_cnt), 32'd1);
    check("rst_idle_after", 32'(busy), 32'd0);
    exp_q.push_back(8'hFF);
    send(8'hFF, 1'b1, -1);
    wait_cycles(4);
    check("ff_consumed", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
